ita_hwpe_bias_repeat: RTL and testbench

ITA_HWPE_BIAS_REPEAT -- requirements
Module: ita_hwpe_bias_repeat

---
 rtl/ita_hwpe_package.sv | 14 +
 rtl/ita_hwpe_bias_buffer.sv | 26 ++
 rtl/ita_hwpe_bias_repeat.sv | 183 ++++++++++++++++++
 tb/tb_ita_hwpe_bias_repeat.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ita_hwpe_package.sv
// rtl/ita_hwpe_package.sv - shared types and constants for the bias repeat block
// Holds the repeat FSM state encoding and the repetition counter width.
package ita_hwpe_package;

  localparam int unsigned BIAS_REPS_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    REPLAY,
    DONE
  } bias_rep_state_e;

endpackage

// File: rtl/ita_hwpe_bias_buffer.sv
// rtl/ita_hwpe_bias_buffer.sv - flop-based bias word store
// One synchronous write port, one asynchronous read port; contents are never reset.
module ita_hwpe_bias_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 36,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ita_hwpe_bias_repeat.sv
// rtl/ita_hwpe_bias_repeat.sv - captures one bias vector and re-emits it reps times
// Optional stall counter output enabled by ITA_BIAS_REPEAT_STALL_CNT_EN.
module ita_hwpe_bias_repeat
  import ita_hwpe_package::*;
#(
  parameter int unsigned BIAS_DW = 32,
  parameter int unsigned DEPTH   = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       start_i,
  input  logic [$clog2(DEPTH+1)-1:0] len_i,
  input  logic [BIAS_REPS_W-1:0]     reps_i,
  input  logic                       bias_valid_i,
  input  logic [BIAS_DW-1:0]         bias_data_i,
  input  logic [BIAS_DW/8-1:0]       bias_strb_i,
  output logic                       bias_ready_o,
  output logic                       bias_valid_o,
  output logic [BIAS_DW-1:0]         bias_data_o,
  output logic [BIAS_DW/8-1:0]       bias_strb_o,
  input  logic                       bias_ready_i,
  output logic                       busy_o,
  output logic                       done_o
`ifdef ITA_BIAS_REPEAT_STALL_CNT_EN
  ,
  output logic [31:0]                stall_cnt_o
`endif
);

  localparam int unsigned LEN_W = $clog2(DEPTH + 1);
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW    = BIAS_DW / 8;

  localparam logic [LEN_W-1:0]       LEN_ONE = LEN_W'(1);
  localparam logic [BIAS_REPS_W-1:0] REP_ONE = BIAS_REPS_W'(1);

  bias_rep_state_e state_q, state_d;

  logic [LEN_W-1:0]       len_q, len_d;
  logic [BIAS_REPS_W-1:0] reps_q, reps_d;
  logic [LEN_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [BIAS_REPS_W-1:0] rep_cnt_q, rep_cnt_d;

  logic                   buf_we;
  logic [SW+BIAS_DW-1:0]  buf_rdata;
  logic [LEN_W-1:0]       len_last;

  assign len_last = len_q - LEN_ONE;

  ita_hwpe_bias_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (SW + BIAS_DW),
    .AW    (AW)
  ) i_buffer (
    .clk_i   (clk_i),
    .we_i    (buf_we),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i ({bias_strb_i, bias_data_i}),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (buf_rdata)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    reps_d       = reps_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rep_cnt_d    = rep_cnt_q;
    bias_valid_o = 1'b0;
    bias_ready_o = 1'b0;
    bias_data_o  = buf_rdata[BIAS_DW-1:0];
    bias_strb_o  = buf_rdata[SW+BIAS_DW-1:BIAS_DW];
    done_o       = 1'b0;
    buf_we       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i == '0 || reps_i == '0) begin
            state_d = DONE;
          end else begin
            len_d     = len_i;
            reps_d    = reps_i;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            rep_cnt_d = '0;
            state_d   = FILL;
          end
        end
      end

      // First emission is a straight passthrough while the words are captured.
      FILL: begin
        bias_valid_o = bias_valid_i;
        bias_ready_o = bias_ready_i;
        bias_data_o  = bias_data_i;
        bias_strb_o  = bias_strb_i;
        if (bias_valid_i && bias_ready_i) begin
          buf_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + LEN_ONE;
          if (wr_ptr_q == len_last) begin
            rep_cnt_d = REP_ONE;
            state_d   = (reps_q == REP_ONE) ? DONE : REPLAY;
          end
        end
      end

      // rep_cnt counts completed emissions, so the fill pass already counts as one.
      REPLAY: begin
        bias_valid_o = 1'b1;
        if (bias_ready_i) begin
          if (rd_ptr_q == len_last) begin
            rd_ptr_d  = '0;
            rep_cnt_d = rep_cnt_q + REP_ONE;
            if (rep_cnt_q + REP_ONE == reps_q) begin
              state_d = DONE;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + LEN_ONE;
          end
        end
      end

      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (clear_i) begin
      state_d   = IDLE;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      rep_cnt_d = '0;
      done_o    = 1'b0;
      buf_we    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      len_q     <= '0;
      reps_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rep_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      reps_q    <= reps_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

  assign busy_o = (state_q != IDLE);

`ifdef ITA_BIAS_REPEAT_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (clear_i) begin
      stall_cnt_q <= '0;
    end else if (state_q == IDLE && start_i) begin
      stall_cnt_q <= '0;
    end else if (bias_valid_o && !bias_ready_i && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ita_hwpe_bias_repeat.sv
// tb/tb_ita_hwpe_bias_repeat.sv - scoreboard bench for ita_hwpe_bias_repeat
// Stimulus pushes expected words into a queue; a negedge monitor pops and compares.
module tb_ita_hwpe_bias_repeat;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH + 1);

  typedef logic [DW/8+DW-1:0] word_t;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              clear_i = 1'b0;
  logic              start_i = 1'b0;
  logic [LW-1:0]     len_i = '0;
  logic [15:0]       reps_i = '0;
  logic              bias_valid_i = 1'b0;
  logic [DW-1:0]     bias_data_i = '0;
  logic [DW/8-1:0]   bias_strb_i = '0;
  logic              bias_ready_o;
  logic              bias_valid_o;
  logic [DW-1:0]     bias_data_o;
  logic [DW/8-1:0]   bias_strb_o;
  logic              bias_ready_i = 1'b1;
  logic              busy_o;
  logic              done_o;
`ifdef ITA_BIAS_REPEAT_STALL_CNT_EN
  logic [31:0]       stall_cnt_o;
`endif

  ita_hwpe_bias_repeat #(.BIAS_DW(DW), .DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .start_i      (start_i),
    .len_i        (len_i),
    .reps_i       (reps_i),
    .bias_valid_i (bias_valid_i),
    .bias_data_i  (bias_data_i),
    .bias_strb_i  (bias_strb_i),
    .bias_ready_o (bias_ready_o),
    .bias_valid_o (bias_valid_o),
    .bias_data_o  (bias_data_o),
    .bias_strb_o  (bias_strb_o),
    .bias_ready_i (bias_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
`ifdef ITA_BIAS_REPEAT_STALL_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int    nvec = 0;
  int    nfail = 0;
  int    cyc = 0;
  int    done_cnt = 0;
  int    done_cyc = 0;
  int    stall_ref = 0;
  int    hs_log[$];
  word_t exp_q[$];
  bit    ready_toggle = 1'b0;
  bit    prev_done = 1'b0;
  bit    prev_stall = 1'b0;
  word_t prev_word = '0;
  word_t wv[4];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk_i) cyc++;

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      bias_ready_i = ready_toggle ? ~bias_ready_i : 1'b1;
    end
  end

  // Monitor: scoreboard pops, hold-while-stalled and done pulse shape.
  always @(negedge clk_i) begin
    word_t w;
    if (prev_stall) begin
      chk("hold_valid", bias_valid_o, 1);
      chk("hold_data", {bias_strb_o, bias_data_o}, prev_word);
    end
    if (bias_valid_o && bias_ready_i) begin
      hs_log.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {bias_strb_o, bias_data_o}, 64'hDEAD);
      end else begin
        w = exp_q.pop_front();
        chk("out_word", {bias_strb_o, bias_data_o}, w);
      end
    end
    if (done_o) begin
      chk("done_valid_low", bias_valid_o, 0);
      chk("done_single", prev_done, 0);
      done_cnt++;
      done_cyc = cyc;
    end
    if (bias_valid_o && !bias_ready_i) stall_ref++;
    prev_done  = done_o;
    prev_stall = bias_valid_o && !bias_ready_i;
    prev_word  = {bias_strb_o, bias_data_o};
  end

  task automatic do_start(input int len, input int reps);
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    len_i   = LW'(len);
    reps_i  = 16'(reps);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  task automatic send_words(input int n);
    int b;
    for (int i = 0; i < n; i++) begin
      bias_valid_i = 1'b1;
      {bias_strb_i, bias_data_i} = wv[i];
      b = 0;
      do begin
        @(negedge clk_i);
        b++;
      end while (!bias_ready_o && b < 50);
      chk("send_accept", bias_ready_o, 1);
      @(posedge clk_i);
      #1;
    end
    bias_valid_i = 1'b0;
  endtask

  task automatic push_exp(input int n, input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < n; i++) exp_q.push_back(wv[i]);
  endtask

  task automatic wait_done(input int prev);
    int b = 0;
    do begin
      @(posedge clk_i);
      #1;
      b++;
    end while (done_cnt == prev && b < 300);
    chk("done_seen", done_cnt, prev + 1);
    chk("idle_after_done", busy_o, 0);
  endtask

  initial begin
    int base, dc, sb, b;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, dc, sb, b;

    // Reset state, with upstream valid asserted to prove ready stays low.
    bias_valid_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid", bias_valid_o, 0);
    chk("rst_ready", bias_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    bias_valid_i = 1'b0;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("post_rst_busy", busy_o, 0);

    // len=4 reps=3, ready stuck high: 12 back-to-back words, stray start ignored.
    wv = '{36'hF_A000_0001, 36'h3_B000_0002, 36'hC_C000_0003, 36'h1_D000_0004};
    push_exp(4, 3);
    base = hs_log.size();
    dc = done_cnt;
    do_start(4, 3);
    send_words(4);
    start_i = 1'b1;
    len_i   = '0;
    reps_i  = '0;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    chk("busy_in_replay", busy_o, 1);
    wait_done(dc);
    chk("t1_empty", exp_q.size(), 0);
    chk("t1_count", hs_log.size() - base, 12);
    if (hs_log.size() - base == 12) begin
      chk("t1_span", hs_log[base+11] - hs_log[base], 11);
      chk("t1_done_lat", done_cyc - hs_log[base+11], 1);
    end

    // len=4 reps=1: passthrough only, further input is never accepted.
    wv = '{36'hE_1111_0000, 36'h7_2222_0000, 36'h5_3333_0000, 36'hA_4444_0000};
    push_exp(4, 1);
    base = hs_log.size();
    dc = done_cnt;
    do_start(4, 1);
    send_words(4);
    bias_valid_i = 1'b1;
    bias_data_i  = 32'h5555_5555;
    chk("t2_ready_after_d", bias_ready_o, 0);
    wait_done(dc);
    chk("t2_ready_idle", bias_ready_o, 0);
    bias_valid_i = 1'b0;
    chk("t2_count", hs_log.size() - base, 4);
    chk("t2_empty", exp_q.size(), 0);

    // len=2 reps=2 with toggling downstream ready.
    wv[0] = 36'h9_0A0A_0A0A;
    wv[1] = 36'h6_0B0B_0B0B;
    push_exp(2, 2);
    base = hs_log.size();
    dc = done_cnt;
    ready_toggle = 1'b1;
    sb = stall_ref;
    do_start(2, 2);
    send_words(2);
    wait_done(dc);
    ready_toggle = 1'b0;
    chk("t3_count", hs_log.size() - base, 4);
    chk("t3_empty", exp_q.size(), 0);
`ifdef ITA_BIAS_REPEAT_STALL_CNT_EN
    chk("t3_stall_cnt", stall_cnt_o, stall_ref - sb);
`endif

    // Degenerate starts: len=0 then reps=0.
    for (int k = 0; k < 2; k++) begin
      bias_valid_i = 1'b1;
      dc = done_cnt;
      @(posedge clk_i);
      #1;
      start_i = 1'b1;
      len_i   = (k == 0) ? LW'(0) : LW'(3);
      reps_i  = (k == 0) ? 16'd5 : 16'd0;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      chk("t4_done_pulse", done_o, 1);
      chk("t4_valid", bias_valid_o, 0);
      chk("t4_ready", bias_ready_o, 0);
      @(posedge clk_i);
      #1;
      chk("t4_done_low", done_o, 0);
      chk("t4_busy_low", busy_o, 0);
      chk("t4_done_cnt", done_cnt, dc + 1);
      bias_valid_i = 1'b0;
    end

    // Reset asserted during the second replay pass, then a fresh run.
    wv[0] = 36'h2_1234_5678;
    wv[1] = 36'h4_8765_4321;
    push_exp(2, 4);
    base = hs_log.size();
    do_start(2, 4);
    send_words(2);
    b = 0;
    while (hs_log.size() - base < 5 && b < 50) begin
      @(posedge clk_i);
      #1;
      b++;
    end
    chk("t5_reached_pass2", hs_log.size() - base, 5);
    #1;
    rst_i = 1'b1;
    #1;
    chk("t5_rst_valid", bias_valid_o, 0);
    chk("t5_rst_ready", bias_ready_o, 0);
    chk("t5_rst_busy", busy_o, 0);
    chk("t5_rst_done", done_o, 0);
`ifdef ITA_BIAS_REPEAT_STALL_CNT_EN
    chk("t5_rst_stall", stall_cnt_o, 0);
`endif
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    wv[0] = 36'h8_CAFE_0001;
    wv[1] = 36'hF_CAFE_0002;
    wv[2] = 36'h3_CAFE_0003;
    push_exp(3, 2);
    base = hs_log.size();
    dc = done_cnt;
    do_start(3, 2);
    send_words(3);
    wait_done(dc);
    chk("t5_count", hs_log.size() - base, 6);
    chk("t5_empty", exp_q.size(), 0);

    // Clear coincident with the final handshake suppresses done.
    wv[0] = 36'h5_0F0F_F0F0;
    push_exp(1, 2);
    base = hs_log.size();
    dc = done_cnt;
    do_start(1, 2);
    send_words(1);
    clear_i = 1'b1;
    @(posedge clk_i);
    #1;
    clear_i = 1'b0;
    chk("t6_busy_low", busy_o, 0);
    chk("t6_done_low", done_o, 0);
    @(posedge clk_i);
    #1;
    chk("t6_no_done", done_cnt, dc);
    chk("t6_count", hs_log.size() - base, 2);
    chk("t6_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
